// File: rtl/key_debounce_ctrl.sv
// -----------------------------------------------------------------------------
// key_debounce_ctrl
//   Debounces one mechanical push-button and produces clean single-cycle
//   press / release / long-press strobes, a debounced level and an 8-bit
//   count of accepted presses.
//
//   Optional feature macro: KEY_LONG_PRESS_EN
//     defined   -> hold counter and key_long strobe are built
//     undefined -> key_long is tied to 0; all other timing is identical
// -----------------------------------------------------------------------------
module key_debounce_ctrl #(
    parameter int unsigned _DEBOUNCE_CONS  = 'd20000,
    parameter int unsigned _LONG_CONS      = 'd10_000_000,
    parameter int unsigned _CNT_WIDTH      = 24,
    parameter int unsigned _KEY_ACTIVE_LOW = 1
) (
    input  logic       io_clk,
    input  logic       io_rst_ram_n,
    input  logic       key_in,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } st_t;

    localparam logic [_CNT_WIDTH-1:0] DB_LAST  = _CNT_WIDTH'(_DEBOUNCE_CONS - 1);
    localparam logic [_CNT_WIDTH-1:0] CNT_ONE  = _CNT_WIDTH'(1);

    // Both counts are terminal compare values; zero or an over-wide value
    // would make a counter wrap inside a state, so refuse to elaborate.
    if ((_DEBOUNCE_CONS < 1) || (((_DEBOUNCE_CONS - 1) >> _CNT_WIDTH) != 0)) begin : g_bad_debounce_cons
        $error("key_debounce_ctrl: _DEBOUNCE_CONS must be >= 1 and fit in _CNT_WIDTH");
    end
    if ((_LONG_CONS < 1) || (((_LONG_CONS - 1) >> _CNT_WIDTH) != 0)) begin : g_bad_long_cons
        $error("key_debounce_ctrl: _LONG_CONS must be >= 1 and fit in _CNT_WIDTH");
    end

    logic                  r_ff1;
    logic                  r_key_s;
    logic                  w_act;
    st_t                   r_st;
    logic [_CNT_WIDTH-1:0] r_db_cnt;
    logic                  r_key_level;
    logic                  r_key_press;
    logic                  r_key_release;
    logic [7:0]            r_press_cnt;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [_CNT_WIDTH-1:0] LONG_LAST = _CNT_WIDTH'(_LONG_CONS - 1);

    logic [_CNT_WIDTH-1:0] r_hold_cnt;
    logic                  r_long_done;
    logic                  r_key_long;
`endif

    // Two-flop synchroniser; the level is normalised to "1 = pressed" before
    // the first flop so both flops can reset to 0 (the released level) and
    // reset release can never look like a press.
    always_ff @(posedge io_clk or negedge io_rst_ram_n) begin
        if (!io_rst_ram_n) begin
            r_ff1   <= 1'b0;
            r_key_s <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            r_ff1   <= (_KEY_ACTIVE_LOW != 0) ? ~key_in : key_in;
            r_key_s <= r_ff1;
        end
    end

    assign w_act = r_key_s;

    // Debounce state machine with registered level, strobes and press count.
    always_ff @(posedge io_clk or negedge io_rst_ram_n) begin
        if (!io_rst_ram_n) begin
            // NOTE: every state and output flop gets an async reset value, so
            // a mid-operation reset drops straight to IDLE with quiet outputs.
            r_st          <= ST_IDLE;
            r_db_cnt      <= '0;
            r_key_level   <= 1'b0;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
            r_press_cnt   <= 8'd0;
`ifdef KEY_LONG_PRESS_EN
            r_hold_cnt    <= '0;
            r_long_done   <= 1'b0;
            r_key_long    <= 1'b0;
`endif
        end else begin
            // Strobes default low so each one lasts exactly one cycle.
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            r_key_long    <= 1'b0;
`endif
            case (r_st)
                ST_IDLE: begin
                    if (w_act) begin
                        r_st     <= ST_PRESS_DB;
                        r_db_cnt <= '0;
                    end
                end

                ST_PRESS_DB: begin
                    if (!w_act) begin
                        r_st <= ST_IDLE;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_st        <= ST_HELD;
                        r_key_level <= 1'b1;
                        r_key_press <= 1'b1;
                        r_press_cnt <= r_press_cnt + 8'd1;
`ifdef KEY_LONG_PRESS_EN
                        r_hold_cnt  <= '0;
                        r_long_done <= 1'b0;
`endif
                    end else begin
                        r_db_cnt <= r_db_cnt + CNT_ONE;
                    end
                end

                ST_HELD: begin
                    if (!w_act) begin
                        r_st     <= ST_RELEASE_DB;
                        r_db_cnt <= '0;
                    end else begin
`ifdef KEY_LONG_PRESS_EN
                        // Hold counter saturates at its terminal value;
                        // long_done keeps the strobe to one per press.
                        if (r_hold_cnt == LONG_LAST) begin
                            if (!r_long_done) begin
                                r_key_long  <= 1'b1;
                                r_long_done <= 1'b1;
                            end
                        end else begin
                            r_hold_cnt <= r_hold_cnt + CNT_ONE;
                        end
`endif
                    end
                end

                ST_RELEASE_DB: begin
                    // Returning to HELD keeps hold_cnt: a release bounce only
                    // pauses the long-press timer.
                    if (w_act) begin
                        r_st <= ST_HELD;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_st          <= ST_IDLE;
                        r_key_level   <= 1'b0;
                        r_key_release <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_st <= ST_IDLE;
                end
            endcase
        end
    end

    assign key_level   = r_key_level;
    assign key_press   = r_key_press;
    assign key_release = r_key_release;
    assign press_cnt   = r_press_cnt;

`ifdef KEY_LONG_PRESS_EN
    assign key_long = r_key_long;
`else
    assign key_long = 1'b0;
`endif

endmodule
